// File: rtl/compute_inverse.sv
// Recovers in1 (mod 128) from a forward result res = 2*in1 + in0 + k, flagging
// results whose parity cannot come from any in1. Three-state valid/ready pipeline.
module compute_inverse (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in0,
   input  logic [7:0] res,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] in1_rec,
   output logic       par_err,
   output logic [7:0] word_cnt,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] in0_q, in0_d;
   logic [7:0] res_q, res_d;
   logic [7:0] in1_rec_q, in1_rec_d;
   logic       par_err_q, par_err_d;
   logic [7:0] word_cnt_q, word_cnt_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] k;
   logic [7:0] diff;

   always_comb begin
      state_d    = state_q;
      in0_d      = in0_q;
      res_d      = res_q;
      in1_rec_d  = in1_rec_q;
      par_err_d  = par_err_q;
      word_cnt_d = word_cnt_q;
      err_cnt_d  = err_cnt_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      // Odd in0 uses k = -1, so the subtraction below wraps to +1.
      k          = in0_q[0] ? 8'hFF : 8'd3;
      diff       = res_q - in0_q - k;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               in0_d   = in0;
               res_d   = res;
               state_d = CALC;
            end
         end
         CALC: begin
            in1_rec_d = {1'b0, diff[7:1]};
            par_err_d = diff[0];
            state_d   = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               word_cnt_d = word_cnt_q + 8'd1;
               if (par_err_q) err_cnt_d = err_cnt_q + 8'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         in0_q      <= '0;
         res_q      <= '0;
         in1_rec_q  <= '0;
         par_err_q  <= 1'b0;
         word_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         in0_q      <= in0_d;
         res_q      <= res_d;
         in1_rec_q  <= in1_rec_d;
         par_err_q  <= par_err_d;
         word_cnt_q <= word_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign in1_rec  = in1_rec_q;
   assign par_err  = par_err_q;
   assign word_cnt = word_cnt_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_compute_inverse.sv
// Scoreboard bench for compute_inverse: expected results queued at input
// handshake, popped and compared at output handshake.
module tb_compute_inverse;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in0;
   logic [7:0] res;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] in1_rec;
   logic       par_err;
   logic [7:0] word_cnt;
   logic [7:0] err_cnt;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [8:0]  sb_q[$];
   logic [7:0]  exp_word = '0;
   logic [7:0]  exp_err  = '0;

   compute_inverse dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in0(in0), .res(res), .out_valid(out_valid), .out_ready(out_ready),
      .in1_rec(in1_rec), .par_err(par_err), .word_cnt(word_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // {par_err, in1_rec}: in1_rec from wrapped difference, par_err from a forward search.
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] r);
      int  kk;
      int  d;
      bit  found;
      kk    = a[0] ? -1 : 3;
      d     = ((int'(r) - int'(a) - kk) % 256 + 256) % 256;
      found = 1'b0;
      for (int x = 0; x < 256; x++)
         if (((2 * x + int'(a) + kk + 512) % 256) == int'(r)) found = 1'b1;
      model = {~found, 8'(d / 2)};
   endfunction

   // Monitor: an output handshake happens at the next posedge when seen here.
   always @(negedge clk) begin
      if (out_valid && out_ready && !rst) begin
         if (sb_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            logic [8:0] e;
            e = sb_q.pop_front();
            check("in1_rec", in1_rec, e[7:0]);
            check("par_err", par_err, e[8]);
            exp_word = exp_word + 8'd1;
            if (e[8]) exp_err = exp_err + 8'd1;
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      sb_q.delete();
      exp_word = '0;
      exp_err  = '0;
   endtask

   // Drives one pair; returns #1 after the accept edge, or after the output
   // handshake when wait_done is set.
   task automatic do_txn(input logic [7:0] a, input logic [7:0] r, input bit wait_done);
      bit ok;
      in0 = a; res = r; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk);
      sb_q.push_back(model(a, r));
      #1 in_valid = 1'b0;
      if (wait_done) begin
         ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin ok = 1'b1; break; end
         end
         if (!ok) check("output_timeout", 0, 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in0 = '0; res = '0; out_ready = 1'b1;
      do_reset();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_in1_rec", in1_rec, 0);
      check("rst_par_err", par_err, 0);

      // Even case with latency probe.
      do_txn(8'd4, 8'd27, 1'b0);
      check("lat_calc_out_valid", out_valid, 0);
      check("lat_calc_in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("lat_done_out_valid", out_valid, 1);
      check("even_in1_rec", in1_rec, 10);
      @(posedge clk); #1;
      check("even_word_cnt", word_cnt, 1);
      check("even_in_ready", in_ready, 1);

      do_txn(8'd5, 8'd18, 1'b1);
      check("odd_in1_rec_hold", in1_rec, 7);
      do_txn(8'd4, 8'd28, 1'b1);
      check("inc_err_cnt", err_cnt, 1);
      do_txn(8'd255, 8'd142, 1'b1);
      check("wrap_in1_rec_hold", in1_rec, 72);
      check("cnt_word", word_cnt, exp_word);
      check("cnt_err", err_cnt, exp_err);

      // Backpressure with input noise outside IDLE.
      out_ready = 1'b0;
      do_txn(8'd4, 8'd28, 1'b0);
      in0 = 8'hAA; res = 8'h55; in_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_in1_rec", in1_rec, 10);
         check("bp_par_err", par_err, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_out_valid", out_valid, 0);
      check("bp_word_cnt", word_cnt, exp_word);
      check("bp_err_cnt", err_cnt, exp_err);

      // Random pairs with random backpressure.
      for (int n = 0; n < 30; n++) begin
         out_ready = 1'($urandom_range(0, 1));
         do_txn(8'($urandom), 8'($urandom), 1'b0);
         for (int w = 0; w < 100 && sb_q.size() != 0; w++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
         end
         if (sb_q.size() != 0) check("rand_timeout", 0, 1);
         check("rand_word_cnt", word_cnt, exp_word);
         check("rand_err_cnt", err_cnt, exp_err);
      end
      out_ready = 1'b1;

      // Reset while in CALC discards the pair.
      in0 = 8'd4; res = 8'd27; in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_in_calc", in_ready, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_word = '0; exp_err = '0;
      check("mid_in_ready", in_ready, 1);
      check("mid_out_valid", out_valid, 0);
      check("mid_word_cnt", word_cnt, 0);
      check("mid_err_cnt", err_cnt, 0);
      repeat (3) begin
         @(posedge clk); #1;
         check("mid_no_output", out_valid, 0);
      end

      // Counter wrap.
      do_reset();
      for (int n = 0; n < 256; n++) begin
         do_txn(8'd4, 8'd28, 1'b1);
         if (n == 254) begin
            check("wrap_word_255", word_cnt, 255);
            check("wrap_err_255", err_cnt, 255);
         end
      end
      check("wrap_word_0", word_cnt, 0);
      check("wrap_err_0", err_cnt, 0);
      check("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
